// File: rtl/c_deskew_pkg.sv
// rtl/c_deskew_pkg.sv - shared FSM state type and default array sizing for the C deskew stage
package c_deskew_pkg;

  localparam int DEF_BITS_C = 16;
  localparam int DEF_DIM    = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

endpackage

// File: rtl/c_delay_line.sv
// rtl/c_delay_line.sv - enabled shift register of fixed depth with synchronous clear
module c_delay_line
  import c_deskew_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = DEF_BITS_C
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] q
);

  logic signed [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/c_deskew.sv
// rtl/c_deskew.sv - realigns the skewed systolic column stream into whole result rows
module c_deskew
  import c_deskew_pkg::*;
#(
  parameter int BITS_C = DEF_BITS_C,
  parameter int DIM    = DEF_DIM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic signed [BITS_C-1:0] Cin  [DIM],
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic                     vld_out,
  output logic [$clog2(DIM)-1:0]   row_idx,
  output logic                     done,
  output logic                     busy
);

  localparam int CNT_W = $clog2(2 * DIM);
  localparam int IDX_W = $clog2(DIM);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DIM - 1);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(DIM - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] row_nxt;
  logic             emit;

  // Column j sees its data j cycles late, so it is delayed DIM-j to line up with column 0.
  for (genvar j = 0; j < DIM; j++) begin : g_col
    c_delay_line #(
      .DEPTH(DIM - j),
      .WIDTH(BITS_C)
    ) u_line (
      .clk(clk),
      .clr(rst),
      .en (en),
      .d  (Cin[j]),
      .q  (Cout[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vld_out <= 1'b0;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vld_out <= emit;
      if (emit) begin
        row_idx <= row_nxt;
      end
    end
  end

  // Row index tracks counter - DIM: zero on the FILL->DRAIN edge, then one per emitted row.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row_idx;
    emit      = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = FILL;
            cnt_nxt   = CNT_ONE;
          end
        end
        FILL: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == CNT_FULL) begin
            state_nxt = DRAIN;
            emit      = 1'b1;
            row_nxt   = '0;
          end
        end
        DRAIN: begin
          cnt_nxt = cnt + 1'b1;
          emit    = 1'b1;
          row_nxt = row_idx + 1'b1;
          if (cnt_nxt == CNT_LAST) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign done = vld_out && (row_idx == ROW_LAST);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_c_deskew.sv
// tb/tb_c_deskew.sv - scoreboard bench for c_deskew with directed frames, stalls and resets
module tb_c_deskew;

  localparam int DIM  = 8;
  localparam int BITS = 16;
  localparam int W    = DIM * BITS;

  typedef struct packed {
    logic [W-1:0] d;
    logic [31:0]  row;
    logic [31:0]  edge_n;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       en;
  logic                       start;
  logic signed [BITS-1:0]     cin  [DIM];
  logic signed [BITS-1:0]     cout [DIM];
  logic                       vld_out;
  logic [$clog2(DIM)-1:0]     row_idx;
  logic                       done;
  logic                       busy;

  logic signed [BITS-1:0]     mat [DIM][DIM];
  exp_t                       sb [$];
  exp_t                       e;
  int                         n_cmp = 0;
  int                         n_bad = 0;
  int                         en_cnt = 0;
  logic                       last_en = 1'b1;
  logic                       last_rst = 1'b1;
  logic [W-1:0]               cur;
  logic [W-1:0]               prev_cout = '0;

  c_deskew #(.BITS_C(BITS), .DIM(DIM)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .Cin    (cin),
    .Cout   (cout),
    .vld_out(vld_out),
    .row_idx(row_idx),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    last_en  <= en;
    last_rst <= rst;
    if (en && !rst) en_cnt <= en_cnt + 1;
  end

  function automatic logic [W-1:0] flat_cout();
    logic [W-1:0] f;
    for (int j = 0; j < DIM; j++) f[j*BITS +: BITS] = cout[j];
    return f;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: pops one expected row per vld_out and checks stall freeze.
  always @(negedge clk) begin
    cur = flat_cout();
    if (!last_rst) begin
      if (!last_en) begin
        chk("stall_vld", W'(vld_out), '0);
        chk("stall_hold", cur, prev_cout);
      end
      if (vld_out) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_row: actual=row%0d required=none", row_idx);
        end else begin
          e = sb.pop_front();
          chk("row_data", cur, e.d);
          chk("row_idx", W'(row_idx), W'(e.row));
          chk("row_edge", W'(en_cnt), W'(e.edge_n));
          chk("row_done", W'(done), W'(e.row == DIM - 1));
          chk("row_busy", W'(busy), W'(e.row != DIM - 1));
        end
      end else begin
        chk("idle_done", W'(done), '0);
      end
    end
    prev_cout = cur;
  end

  task automatic set_mat(input int mode);
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++)
        case (mode)
          0: mat[r][j] = 16'(16 * r + j);
          1: mat[r][j] = ((r + j) % 2 == 1) ? 16'sh7fff : 16'sh8000;
          default: mat[r][j] = 16'(-(16 * r + j) - 1);
        endcase
  endtask

  task automatic drive(input logic e_v, input logic s_v, input int k, input logic use_mat);
    @(negedge clk);
    en    = e_v;
    start = s_v;
    for (int j = 0; j < DIM; j++) begin
      if (use_mat && k - j >= 0 && k - j < DIM) cin[j] = mat[k-j][j];
      else cin[j] = 16'($urandom);
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic drive_frame(input int s1_at, input int s1_len, input int s2_at, input int s2_len,
                             input int mid_start_k, input int abort_k, input logic b2b);
    int   base;
    exp_t x;
    for (int k = 0; k <= 2 * DIM - 2; k++) begin
      if (k == abort_k) begin
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("abort_vld", W'(vld_out), '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_cout", flat_cout(), '0);
        chk("abort_row_idx", W'(row_idx), '0);
        rst   = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        return;
      end
      if (k == s1_at) repeat (s1_len) drive(1'b0, 1'b1, 0, 1'b0);
      if (k == s2_at) repeat (s2_len) drive(1'b0, 1'b1, 0, 1'b0);
      drive(1'b1, (k == 0 || k == mid_start_k), k, 1'b1);
      if (k == 0) begin
        if (b2b) chk("b2b_done", W'(done), W'(1));
        base = en_cnt;
        for (int r = 0; r < DIM; r++) begin
          for (int j = 0; j < DIM; j++) x.d[j*BITS +: BITS] = mat[r][j];
          x.row    = r;
          x.edge_n = base + DIM + r;
          sb.push_back(x);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    for (int j = 0; j < DIM; j++) cin[j] = 16'(100 + j);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cout", flat_cout(), '0);
    chk("reset_vld", W'(vld_out), '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_row_idx", W'(row_idx), '0);
    rst = 1'b0;
    drive_idle(3);

    drive(1'b0, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    chk("start_no_en_busy", W'(busy), '0);
    drive_idle(2);

    set_mat(0);
    drive_frame(-1, 0, -1, 0, -1, -1, 1'b0);
    drive_idle(3);
    chk("idle_busy", W'(busy), '0);

    drive_frame(5, 3, 11, 2, -1, -1, 1'b0);
    drive_idle(2);

    set_mat(1);
    drive_frame(-1, 0, -1, 0, -1, -1, 1'b0);
    set_mat(2);
    drive_frame(-1, 0, -1, 0, 3, -1, 1'b1);
    drive_idle(3);

    set_mat(0);
    drive_frame(-1, 0, -1, 0, -1, DIM + 3, 1'b0);
    drive_idle(2);
    set_mat(2);
    drive_frame(-1, 0, -1, 0, -1, -1, 1'b0);
    drive_idle(4);

    chk("sb_drained", W'(sb.size()), '0);
    chk("end_busy", W'(busy), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/c_deskew.md
C_DESKEW -- requirements
Module: c_deskew

Interface
REQ-001 Parameter BITS_C, default 16, width of one signed result element.
REQ-002 Parameter DIM, default 8, array dimension (rows = columns = DIM), DIM >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  advance enable; when low, all internal state and outputs hold except vld_out and done.
REQ-006 start  input  1  marks the enabled cycle carrying element C[0][0] on Cin[0].
REQ-007 Cin  input  DIM x BITS_C signed  skewed column stream from the array; element C[r][j] arrives on Cin[j] on enabled cycle r+j after start.
REQ-008 Cout  output  DIM x BITS_C signed  one aligned row C[r][0..DIM-1].
REQ-009 vld_out  output  1  Cout holds a new row this cycle.
REQ-010 row_idx  output  $clog2(DIM)  row index r of the row on Cout; valid when vld_out=1.
REQ-011 done  output  1  one-cycle pulse with the last row (r=DIM-1).
REQ-012 busy  output  1  high from accepted start until done.

Function
REQ-013 Per column j, delay line of DIM-j registers, shifting only when en=1; Cout[j] = last stage (all outputs registered).
REQ-014 Start edge = enabled edge at which start=1 is sampled; counts as enabled edge 1. Row r is on Cout after enabled edge DIM+r.
REQ-015 FSM states: IDLE, FILL, DRAIN.
REQ-016 IDLE -> FILL on enabled edge with start=1; the enabled-edge counter loads 1.
REQ-017 FILL: counter increments per enabled edge; -> DRAIN on the edge that makes counter = DIM (row 0 emitted on that edge).
REQ-018 DRAIN: one row per enabled edge; -> IDLE on the edge emitting row DIM-1.
REQ-019 Counter width $clog2(2*DIM); never wraps within a frame.
REQ-020 vld_out registered: 1 only for the cycle after an enabled edge that emits a row; 0 after any edge with en=0, and 0 in IDLE.
REQ-021 row_idx = counter - DIM on emitting edges; holds otherwise.
REQ-022 done = vld_out AND row_idx = DIM-1.
REQ-023 busy = state != IDLE.
REQ-024 start ignored when en=0 or state != IDLE; no error flag.
REQ-025 Stall (en=0) in FILL or DRAIN: delay lines, counter, state and Cout freeze; the frame resumes exactly where it stopped.
REQ-026 Earliest next start: enabled edge after the one emitting row DIM-1 (i.e., while done=1). Delay lines need no flush because data of both frames stays column-aligned.
REQ-027 No arithmetic on data; values pass bit-exact, sign preserved.

Reset
REQ-028 rst=1 at an edge: all delay-line registers and Cout cleared to 0; vld_out=0, done=0, row_idx=0, counter=0, state=IDLE; reset overrides en and start.
REQ-029 Reset mid-frame abandons the frame; no partial rows are emitted afterwards.

Structure
REQ-030 Shared package holds the FSM state enum and the default BITS_C/DIM constants used with the A/B skew memories.
REQ-031 One sub-module is natural: c_delay_line (parameterised depth, width BITS_C, enable, sync clear), instantiated DIM times with depth DIM-j.
REQ-032 Target size 120-400 lines of RTL in total.

Verification
REQ-033 Reset: drive Cin nonzero and en=1 with rst=1 for 2 edges -> Cout all 0, vld_out=0, busy=0.
REQ-034 Nominal frame, DIM=8, C[r][j]=16*r+j, skewed, en=1 continuous -> rows 0..7 on Cout after enabled edges 8..15; row_idx 0..7; done high with row 7 only.
REQ-035 Stall: same frame with en=0 for 3 cycles after edge 5 and 2 cycles after edge 11 -> same rows in order; vld_out=0 and Cout unchanged during stalls.
REQ-036 Signed extremes: C[r][j] alternating -32768 and 32767 -> bit-exact output, no sign corruption.
REQ-037 Back-to-back: second start while done=1 -> second frame row 0 after its enabled edge 8; no gap or mixing; start pulsed mid-frame is ignored.
REQ-038 Reset mid-DRAIN after row 3 -> next cycle vld_out=0, IDLE; a new frame afterwards is correct from row 0.
